// File: rtl/desc_rd_arbiter.sv
// Round-robin AXI4 AR arbiter shared by descriptor channels, with RID-based R routing,
// a per-channel outstanding-burst limit and a sticky error flag for beats nobody is waiting for.
module desc_rd_arbiter #(
  parameter int NUM_CHANNELS    = 8,
  parameter int CHAN_WIDTH      = $clog2(NUM_CHANNELS),
  parameter int ADDR_WIDTH      = 64,
  parameter int AXI_ID_WIDTH    = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CHANNELS-1:0]              cfg_channel_reset,
  input  logic [NUM_CHANNELS-1:0]              s_ar_valid,
  output logic [NUM_CHANNELS-1:0]              s_ar_ready,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   s_ar_addr,
  input  logic [NUM_CHANNELS*8-1:0]            s_ar_len,
  output logic                                 m_ar_valid,
  input  logic                                 m_ar_ready,
  output logic [ADDR_WIDTH-1:0]                m_ar_addr,
  output logic [7:0]                           m_ar_len,
  output logic [AXI_ID_WIDTH-1:0]              m_ar_id,
  output logic [2:0]                           m_ar_size,
  output logic [1:0]                           m_ar_burst,
  input  logic                                 m_r_valid,
  output logic                                 m_r_ready,
  input  logic [255:0]                         m_r_data,
  input  logic [1:0]                           m_r_resp,
  input  logic                                 m_r_last,
  input  logic [AXI_ID_WIDTH-1:0]              m_r_id,
  output logic [NUM_CHANNELS-1:0]              s_r_valid,
  input  logic [NUM_CHANNELS-1:0]              s_r_ready,
  output logic [255:0]                         s_r_data,
  output logic [1:0]                           s_r_resp,
  output logic                                 s_r_last,
  output logic [NUM_CHANNELS-1:0]              chan_idle,
  output logic                                 orphan_error
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [AXI_ID_WIDTH-1:0] ID_LIMIT  = AXI_ID_WIDTH'(NUM_CHANNELS);
  localparam logic [CHAN_WIDTH-1:0]   LAST_CHAN = CHAN_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CHAN_WIDTH:0]     CHAN_NUM  = (CHAN_WIDTH+1)'(NUM_CHANNELS);

  logic [CNT_WIDTH-1:0]  count [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_CHANNELS];
  logic [7:0]            len_arr [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] eligible;
  logic [CHAN_WIDTH-1:0] ptr, winner, ptr_next, r_chan, idx;
  logic [CHAN_WIDTH:0]   sum;
  logic                  slot_free, found, grant, r_orphan, r_done;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      addr_arr[c]  = s_ar_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
      len_arr[c]   = s_ar_len[c*8 +: 8];
      eligible[c]  = s_ar_valid[c] & ~cfg_channel_reset[c] & (count[c] < CNT_MAX);
      chan_idle[c] = (count[c] == '0);
    end
  end

  // The single-entry AR register can take a new request when empty or draining this cycle.
  assign slot_free = ~m_ar_valid | m_ar_ready;

  // Rotating priority: first eligible channel at or after ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum = {1'b0, ptr} + (CHAN_WIDTH+1)'(i);
      if (sum >= CHAN_NUM) sum = sum - CHAN_NUM;
      idx = sum[CHAN_WIDTH-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign grant      = slot_free & found;
  assign s_ar_ready = grant ? (NUM_CHANNELS'(1) << winner) : '0;
  assign ptr_next   = (winner == LAST_CHAN) ? '0 : winner + 1'b1;

  // Beats for unknown IDs or idle channels are swallowed so the fabric never stalls on them.
  assign r_chan    = m_r_id[CHAN_WIDTH-1:0];
  assign r_orphan  = (m_r_id >= ID_LIMIT) || (count[r_chan] == '0);
  assign s_r_valid = (m_r_valid & ~r_orphan) ? (NUM_CHANNELS'(1) << r_chan) : '0;
  assign m_r_ready = r_orphan | s_r_ready[r_chan];
  assign r_done    = m_r_valid & m_r_ready & m_r_last & ~r_orphan;

  assign s_r_data   = m_r_data;
  assign s_r_resp   = m_r_resp;
  assign s_r_last   = m_r_last;
  assign m_ar_size  = 3'b101;
  assign m_ar_burst = 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ar_valid   <= 1'b0;
      m_ar_addr    <= '0;
      m_ar_len     <= '0;
      m_ar_id      <= '0;
      ptr          <= '0;
      orphan_error <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) count[c] <= '0;
    end else begin
      if (grant) begin
        m_ar_valid <= 1'b1;
        m_ar_addr  <= addr_arr[winner];
        m_ar_len   <= len_arr[winner];
        m_ar_id    <= AXI_ID_WIDTH'(winner);
        ptr        <= ptr_next;
      end else if (m_ar_ready) begin
        m_ar_valid <= 1'b0;
      end
      if (m_r_valid && r_orphan) orphan_error <= 1'b1;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if ((grant && winner == CHAN_WIDTH'(c)) && !(r_done && r_chan == CHAN_WIDTH'(c)))
          count[c] <= count[c] + 1'b1;
        else if (!(grant && winner == CHAN_WIDTH'(c)) && (r_done && r_chan == CHAN_WIDTH'(c)))
          count[c] <= count[c] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_desc_rd_arbiter.sv
// Bench for desc_rd_arbiter: directed vector table, hand-written corner sequences and
// random traffic, all checked cycle by cycle against a transaction-level reference model.
module tb_desc_rd_arbiter;
  localparam int N  = 8;
  localparam int AW = 64;
  localparam int IW = 8;
  localparam int MO = 4;

  logic            clk, rst_n;
  logic [N-1:0]    cfg_channel_reset, s_ar_valid, s_ar_ready;
  logic [N*AW-1:0] s_ar_addr;
  logic [N*8-1:0]  s_ar_len;
  logic            m_ar_valid, m_ar_ready;
  logic [AW-1:0]   m_ar_addr;
  logic [7:0]      m_ar_len;
  logic [IW-1:0]   m_ar_id;
  logic [2:0]      m_ar_size;
  logic [1:0]      m_ar_burst;
  logic            m_r_valid, m_r_ready, m_r_last, s_r_last;
  logic [255:0]    m_r_data, s_r_data;
  logic [1:0]      m_r_resp, s_r_resp;
  logic [IW-1:0]   m_r_id;
  logic [N-1:0]    s_r_valid, s_r_ready, chan_idle;
  logic            orphan_error;

  desc_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cfg_channel_reset(cfg_channel_reset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
    .m_ar_id(m_ar_id), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_r_last(m_r_last), .m_r_id(m_r_id), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .chan_idle(chan_idle), .orphan_error(orphan_error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad;

  // Reference model: outstanding bursts per channel, RR pointer, pending AR, sticky error
  int          mcnt[N];
  int          mptr;
  bit          mav, morph;
  logic [63:0] maddr;
  logic [7:0]  mlen;
  int          mid;

  logic [N-1:0] pre_ar_ready, pre_r_valid;
  logic         pre_r_ready;

  typedef struct {
    logic [N-1:0] ar_valid;
    logic         m_ready;
    logic [N-1:0] exp_ar_ready;
    logic         exp_mav;
    logic [7:0]   exp_id;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [63:0] chan_addr(input int c);
    return 64'h1000_0000 + 64'(c) * 64'h100;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) mcnt[c] = 0;
    mptr = 0; mav = 0; morph = 0; maddr = '0; mlen = '0; mid = 0;
  endtask

  task automatic idle_inputs();
    cfg_channel_reset = '0; s_ar_valid = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_last = 1'b0; m_r_id = '0; m_r_data = '0; m_r_resp = '0;
    s_r_ready = '0;
  endtask

  task automatic do_reset();
    logic [N-1:0] ones;
    ones = '1;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst m_ar_valid", m_ar_valid, 0);
    chk("rst m_ar_addr", m_ar_addr, 0);
    chk("rst m_ar_id", m_ar_id, 0);
    chk("rst chan_idle", chan_idle, ones);
    chk("rst orphan_error", orphan_error, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Driver + scoreboard for one clock: inputs were set at the preceding negedge.
  task automatic cycle();
    int win, rid;
    bit found, slot, orph, e_rr;
    logic [N-1:0] e_ar_ready, e_rv, e_idle;
    #1;
    slot = !mav || m_ar_ready;
    found = 0; win = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (!found && s_ar_valid[c] && !cfg_channel_reset[c] && mcnt[c] < MO) begin
        found = 1; win = c;
      end
    end
    e_ar_ready = '0;
    if (slot && found) e_ar_ready[win] = 1'b1;
    rid = int'(m_r_id);
    if (rid >= N) orph = 1; else orph = (mcnt[rid] == 0);
    e_rv = '0;
    if (m_r_valid && !orph) e_rv[rid] = 1'b1;
    e_rr = orph ? 1'b1 : s_r_ready[rid];
    chk("s_ar_ready", s_ar_ready, e_ar_ready);
    chk("s_r_valid", s_r_valid, e_rv);
    chk("m_r_ready", m_r_ready, e_rr);
    chk("s_r_data", s_r_data[63:0] ^ s_r_data[255:192], m_r_data[63:0] ^ m_r_data[255:192]);
    chk("s_r_resp_last", {s_r_resp, s_r_last}, {m_r_resp, m_r_last});
    pre_ar_ready = s_ar_ready; pre_r_valid = s_r_valid; pre_r_ready = m_r_ready;
    @(posedge clk);
    if (slot && found) begin
      mcnt[win]++;
      mptr  = (win + 1) % N;
      mav   = 1;
      maddr = s_ar_addr[win*AW +: AW];
      mlen  = s_ar_len[win*8 +: 8];
      mid   = win;
    end else if (m_ar_ready) begin
      mav = 0;
    end
    if (m_r_valid && orph) morph = 1;
    if (m_r_valid && !orph && e_rr && m_r_last) mcnt[rid]--;
    @(negedge clk);
    for (int c = 0; c < N; c++) e_idle[c] = (mcnt[c] == 0);
    chk("m_ar_valid", m_ar_valid, mav);
    chk("m_ar_addr", m_ar_addr, maddr);
    chk("m_ar_len", m_ar_len, mlen);
    chk("m_ar_id", m_ar_id, 64'(mid));
    chk("chan_idle", chan_idle, e_idle);
    chk("orphan_error", orphan_error, morph);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    idle_inputs();
    for (int c = 0; c < N; c++) begin
      s_ar_addr[c*AW +: AW] = chan_addr(c);
      s_ar_len[c*8 +: 8]    = 8'(c + 1);
    end
    model_reset();
    @(negedge clk);
    do_reset();
    chk("ar_size", m_ar_size, 3'b101);
    chk("ar_burst", m_ar_burst, 2'b01);

    // Vector table: RR over ch0/1/3, a 5-cycle stall, release, drain
    for (int i = 0; i < 6; i++) begin
      tbl[i].ar_valid = 8'b0000_1011; tbl[i].m_ready = 1'b1; tbl[i].exp_mav = 1'b1;
    end
    tbl[0].exp_ar_ready = 8'h01; tbl[0].exp_id = 8'd0;
    tbl[1].exp_ar_ready = 8'h02; tbl[1].exp_id = 8'd1;
    tbl[2].exp_ar_ready = 8'h08; tbl[2].exp_id = 8'd3;
    tbl[3].exp_ar_ready = 8'h01; tbl[3].exp_id = 8'd0;
    tbl[4].exp_ar_ready = 8'h02; tbl[4].exp_id = 8'd1;
    tbl[5].exp_ar_ready = 8'h08; tbl[5].exp_id = 8'd3;
    for (int i = 6; i < 11; i++) tbl[i] = '{8'b0000_1011, 1'b0, 8'h00, 1'b1, 8'd3};
    tbl[11] = '{8'b0000_1011, 1'b1, 8'h01, 1'b1, 8'd0};
    tbl[12] = '{8'b0000_0000, 1'b1, 8'h00, 1'b0, 8'd0};
    for (int i = 0; i < 13; i++) begin
      s_ar_valid = tbl[i].ar_valid;
      m_ar_ready = tbl[i].m_ready;
      cycle();
      chk($sformatf("tbl%0d s_ar_ready", i), pre_ar_ready, tbl[i].exp_ar_ready);
      chk($sformatf("tbl%0d m_ar_valid", i), m_ar_valid, tbl[i].exp_mav);
      chk($sformatf("tbl%0d m_ar_id", i), m_ar_id, tbl[i].exp_id);
      chk($sformatf("tbl%0d m_ar_addr", i), m_ar_addr, chan_addr(int'(tbl[i].exp_id)));
    end

    // Single ch2 burst and its one-beat response
    do_reset();
    s_ar_addr[2*AW +: AW] = 64'h1000;
    s_ar_len[2*8 +: 8] = 8'd0;
    s_ar_valid = 8'h04; m_ar_ready = 1'b1;
    cycle();
    chk("ch2 grant", pre_ar_ready, 8'h04);
    chk("ch2 m_ar_valid", m_ar_valid, 1);
    chk("ch2 m_ar_id", m_ar_id, 2);
    chk("ch2 m_ar_addr", m_ar_addr, 64'h1000);
    chk("ch2 m_ar_len", m_ar_len, 0);
    chk("ch2 busy", chan_idle[2], 0);
    s_ar_valid = '0;
    m_r_valid = 1'b1; m_r_id = 8'd2; m_r_last = 1'b1; s_r_ready = 8'h04;
    m_r_data = {8{$urandom}};
    cycle();
    chk("ch2 r route", pre_r_valid, 8'h04);
    chk("ch2 r ready", pre_r_ready, 1);
    chk("ch2 idle", chan_idle[2], 1);
    m_r_valid = 1'b0;

    // Ch1 hits the outstanding limit, then one R last frees a slot
    s_ar_valid = 8'h02;
    for (int i = 0; i < MO; i++) begin
      cycle();
      chk($sformatf("ch1 grant%0d", i), pre_ar_ready, 8'h02);
    end
    cycle();
    chk("ch1 limit", pre_ar_ready, 8'h00);
    m_r_valid = 1'b1; m_r_id = 8'd1; m_r_last = 1'b1; s_r_ready = 8'h02;
    cycle();
    chk("ch1 limit during r", pre_ar_ready, 8'h00);
    chk("ch1 r route", pre_r_valid, 8'h02);
    m_r_valid = 1'b0;
    cycle();
    chk("ch1 regrant", pre_ar_ready, 8'h02);
    s_ar_valid = '0;

    // Orphan beat on an idle channel
    m_r_valid = 1'b1; m_r_id = 8'd5; m_r_last = 1'b1; s_r_ready = 8'h00;
    cycle();
    chk("orphan ready", pre_r_ready, 1);
    chk("orphan no valid", pre_r_valid, 8'h00);
    chk("orphan flag", orphan_error, 1);
    m_r_valid = 1'b0;
    cycle();
    cycle();
    chk("orphan sticky", orphan_error, 1);

    // Ch4: same-cycle grant and R last, then channel reset blocks grants only
    s_ar_valid = 8'h10;
    cycle();
    cycle();
    m_r_valid = 1'b1; m_r_id = 8'd4; m_r_last = 1'b1; s_r_ready = 8'h10;
    cycle();
    chk("ch4 same grant", pre_ar_ready, 8'h10);
    chk("ch4 same r", pre_r_valid, 8'h10);
    cfg_channel_reset = 8'h10;
    cycle();
    chk("ch4 blocked", pre_ar_ready, 8'h00);
    chk("ch4 r routed", pre_r_valid, 8'h10);
    chk("ch4 one left", chan_idle[4], 0);
    cycle();
    chk("ch4 blocked2", pre_ar_ready, 8'h00);
    chk("ch4 idle", chan_idle[4], 1);
    idle_inputs();

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      s_ar_valid = 8'($urandom);
      cfg_channel_reset = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      m_ar_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) s_ar_addr[c*AW +: AW] = {$urandom, $urandom};
      s_ar_len = {$urandom, $urandom};
      m_r_valid = $urandom_range(0, 1);
      m_r_id = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      m_r_last = $urandom_range(0, 1);
      m_r_resp = 2'($urandom);
      s_r_ready = 8'($urandom);
      m_r_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
